// File: rtl/exe_pkg.sv
// Shared encodings for the execute stage: ALU opcodes, branch types,
// forward selects and the multiplier state encoding.
package exe_pkg;

    localparam int unsigned XLEN = 32;

    localparam logic [3:0] CMD_ADD = 4'b0000;
    localparam logic [3:0] CMD_SUB = 4'b0010;
    localparam logic [3:0] CMD_AND = 4'b0100;
    localparam logic [3:0] CMD_OR  = 4'b0101;
    localparam logic [3:0] CMD_NOR = 4'b0110;
    localparam logic [3:0] CMD_XOR = 4'b0111;
    localparam logic [3:0] CMD_SLL = 4'b1000;
    localparam logic [3:0] CMD_SRL = 4'b1001;
    localparam logic [3:0] CMD_SRA = 4'b1010;
    localparam logic [3:0] CMD_SLT = 4'b1011;
    localparam logic [3:0] CMD_MUL = 4'b1100;
    localparam logic [3:0] CMD_NOP = 4'b1111;

    localparam logic [1:0] BR_NONE = 2'b00;
    localparam logic [1:0] BR_BEZ  = 2'b01;
    localparam logic [1:0] BR_BNE  = 2'b10;
    localparam logic [1:0] BR_JMP  = 2'b11;

    localparam logic [1:0] FWD_REG = 2'b00;
    localparam logic [1:0] FWD_MEM = 2'b01;
    localparam logic [1:0] FWD_WB  = 2'b10;

    typedef enum logic [1:0] {
        MUL_IDLE = 2'b00,
        MUL_BUSY = 2'b01,
        MUL_DONE = 2'b10
    } mul_state_t;

    // Select between the register value and the two forwarding sources.
    function automatic logic [XLEN-1:0] fwd_mux(
        input logic [1:0]      sel,
        input logic [XLEN-1:0] reg_val,
        input logic [XLEN-1:0] mem_val,
        input logic [XLEN-1:0] wb_val
    );
        case (sel)
            FWD_MEM: fwd_mux = mem_val;
            FWD_WB:  fwd_mux = wb_val;
            default: fwd_mux = reg_val;
        endcase
    endfunction

endpackage

// File: rtl/mul_seq.sv
// Radix-2 shift-add sequential multiplier producing the low XLEN product bits.
module mul_seq
    import exe_pkg::*;
#(
    parameter int unsigned MUL_STEPS = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic [XLEN-1:0] product,
    output logic            busy,
    output logic            done
);

    localparam int unsigned CW = (MUL_STEPS > 1) ? $clog2(MUL_STEPS) : 1;

    mul_state_t      state, state_next;
    logic [XLEN-1:0] a_q, b_q, prod_q;
    logic [CW-1:0]   count_q;

    always_ff @(posedge clk) begin
        if (rst) state <= MUL_IDLE;
        else     state <= state_next;
    end

    // Operands are captured at start because forward sources move while stalled.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_q     <= '0;
            b_q     <= '0;
            prod_q  <= '0;
            count_q <= '0;
        end else begin
            case (state)
                MUL_IDLE: begin
                    if (start) begin
                        a_q     <= a;
                        b_q     <= b;
                        prod_q  <= '0;
                        count_q <= '0;
                    end
                end
                MUL_BUSY: begin
                    if (b_q[0]) prod_q <= prod_q + a_q;
                    a_q     <= a_q << 1;
                    b_q     <= b_q >> 1;
                    count_q <= count_q + CW'(1);
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_next = state;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            MUL_IDLE: begin
                if (start) begin
                    busy       = 1'b1;
                    state_next = MUL_BUSY;
                end
            end
            MUL_BUSY: begin
                busy = 1'b1;
                if (count_q == CW'(MUL_STEPS - 1)) state_next = MUL_DONE;
            end
            MUL_DONE: begin
                done       = 1'b1;
                state_next = MUL_IDLE;
            end
            default: state_next = MUL_IDLE;
        endcase
    end

    assign product = prod_q;

endmodule

// File: rtl/exe_stage.sv
// Execute stage: operand forwarding, ALU, branch resolution and the
// sequential multiplier that stalls the front of the pipeline while it runs.
module exe_stage
    import exe_pkg::*;
#(
    parameter int unsigned MUL_STEPS = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [3:0]      EXE_CMD,
    input  logic [XLEN-1:0] Val1,
    input  logic [XLEN-1:0] Val2,
    input  logic [XLEN-1:0] Reg2,
    input  logic [XLEN-1:0] PC_in,
    input  logic [1:0]      Branch_Type,
    input  logic            is_imm,
    input  logic [1:0]      fwd_sel_a,
    input  logic [1:0]      fwd_sel_b,
    input  logic [XLEN-1:0] mem_fwd_val,
    input  logic [XLEN-1:0] wb_fwd_val,
    output logic [XLEN-1:0] alu_result,
    output logic [XLEN-1:0] st_val,
    output logic            br_taken,
    output logic [XLEN-1:0] br_addr,
    output logic            busy
);

    logic [XLEN-1:0] op_a, op_b, b_fwd, alu_raw, mul_product;
    logic [4:0]      shamt;
    logic            mul_done;

    assign op_a   = fwd_mux(fwd_sel_a, Val1, mem_fwd_val, wb_fwd_val);
    assign b_fwd  = fwd_mux(fwd_sel_b, Val2, mem_fwd_val, wb_fwd_val);
    assign op_b   = is_imm ? Val2 : b_fwd;
    assign st_val = fwd_mux(fwd_sel_b, Reg2, mem_fwd_val, wb_fwd_val);
    assign shamt  = op_b[4:0];

    // MUL is never visible here: it is busy or done whenever EXE_CMD is MUL.
    always_comb begin
        alu_raw = '0;
        case (EXE_CMD)
            CMD_ADD: alu_raw = op_a + op_b;
            CMD_SUB: alu_raw = op_a - op_b;
            CMD_AND: alu_raw = op_a & op_b;
            CMD_OR:  alu_raw = op_a | op_b;
            CMD_NOR: alu_raw = ~(op_a | op_b);
            CMD_XOR: alu_raw = op_a ^ op_b;
            CMD_SLL: alu_raw = op_a << shamt;
            CMD_SRL: alu_raw = op_a >> shamt;
            CMD_SRA: alu_raw = XLEN'($signed(op_a) >>> shamt);
            CMD_SLT: alu_raw = XLEN'($signed(op_a) < $signed(op_b));
            default: alu_raw = '0;
        endcase
    end

    mul_seq #(.MUL_STEPS(MUL_STEPS)) u_mul (
        .clk     (clk),
        .rst     (rst),
        .start   (EXE_CMD == CMD_MUL),
        .a       (op_a),
        .b       (op_b),
        .product (mul_product),
        .busy    (busy),
        .done    (mul_done)
    );

    always_comb begin
        if (busy)          alu_result = '0;
        else if (mul_done) alu_result = mul_product;
        else               alu_result = alu_raw;
    end

    assign br_addr = PC_in + (Val2 << 2);

    always_comb begin
        br_taken = 1'b0;
        case (Branch_Type)
            BR_BEZ:  br_taken = (op_a == '0);
            BR_BNE:  br_taken = (op_a != st_val);
            BR_JMP:  br_taken = 1'b1;
            default: br_taken = 1'b0;
        endcase
    end

endmodule

// File: tb/tb_exe_stage.sv
// Randomized scoreboard bench for exe_stage against a behavioural model.
module tb_exe_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  EXE_CMD;
    logic [31:0] Val1, Val2, Reg2, PC_in, mem_fwd_val, wb_fwd_val;
    logic [1:0]  Branch_Type, fwd_sel_a, fwd_sel_b;
    logic        is_imm;
    logic [31:0] alu_result, st_val, br_addr;
    logic        br_taken, busy;

    exe_stage #(.MUL_STEPS(32)) dut (
        .clk(clk), .rst(rst), .EXE_CMD(EXE_CMD), .Val1(Val1), .Val2(Val2),
        .Reg2(Reg2), .PC_in(PC_in), .Branch_Type(Branch_Type), .is_imm(is_imm),
        .fwd_sel_a(fwd_sel_a), .fwd_sel_b(fwd_sel_b), .mem_fwd_val(mem_fwd_val),
        .wb_fwd_val(wb_fwd_val), .alu_result(alu_result), .st_val(st_val),
        .br_taken(br_taken), .br_addr(br_addr), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] alu;
        logic [31:0] st;
        logic [31:0] ba;
        logic        bt;
        int          busy_len;
    } exp_t;

    exp_t sb[$];
    exp_t me;
    int   n_cmp = 0;
    int   n_fail = 0;
    int   run = 0;
    bit   mon_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] fsel(input logic [1:0] s, input logic [31:0] v,
                                         input logic [31:0] m, input logic [31:0] w);
        if (s == 2'd1) return m;
        if (s == 2'd2) return w;
        return v;
    endfunction

    // Reference ALU: straight arithmetic on the operation definitions.
    function automatic logic [31:0] model_alu(input logic [3:0] c, input logic [31:0] a,
                                              input logic [31:0] b);
        int unsigned sh;
        sh = int'(b % 32);
        case (c)
            4'd0:  return a + b;
            4'd2:  return a - b;
            4'd4:  return a & b;
            4'd5:  return a | b;
            4'd6:  return ~(a | b);
            4'd7:  return a ^ b;
            4'd8:  return a << sh;
            4'd9:  return a >> sh;
            4'd10: return 32'($signed(a) >>> sh);
            4'd11: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'd12: return 32'(64'(a) * 64'(b));
            default: return 32'd0;
        endcase
    endfunction

    task automatic issue(input logic [3:0] cmd, input logic [31:0] v1, input logic [31:0] v2,
                         input logic [31:0] r2, input logic [31:0] pc, input logic [1:0] bt,
                         input logic imm, input logic [1:0] fa, input logic [1:0] fb,
                         input logic [31:0] mv, input logic [31:0] wv);
        exp_t        e;
        logic [31:0] a, b, st;
        int          k;
        bit          seen;
        @(posedge clk); #1;
        EXE_CMD = cmd; Val1 = v1; Val2 = v2; Reg2 = r2; PC_in = pc; Branch_Type = bt;
        is_imm = imm; fwd_sel_a = fa; fwd_sel_b = fb; mem_fwd_val = mv; wb_fwd_val = wv;
        a  = fsel(fa, v1, mv, wv);
        st = fsel(fb, r2, mv, wv);
        b  = imm ? v2 : fsel(fb, v2, mv, wv);
        e.alu = model_alu(cmd, a, b);
        e.st  = st;
        e.ba  = pc + v2 * 4;
        e.bt  = (bt == 2'd1) ? (a == 0) : (bt == 2'd2) ? (a != st) : (bt == 2'd3);
        e.busy_len = (cmd == 4'b1100) ? 33 : 0;
        sb.push_back(e);
        mon_en = 1'b1;
        if (cmd == 4'b1100) begin
            k = 1;
            seen = 1'b0;
            for (int c = 0; c < 100; c++) begin
                @(negedge clk);
                if (!busy) begin
                    seen = 1'b1;
                    break;
                end
                k++;
                @(posedge clk); #1;
                if (k <= 20) begin
                    Val1 = $urandom; Val2 = $urandom; Reg2 = $urandom;
                    mem_fwd_val = $urandom; wb_fwd_val = $urandom;
                    fwd_sel_a = 2'($urandom_range(0, 3)); fwd_sel_b = 2'($urandom_range(0, 3));
                end else begin
                    Val1 = v1; Val2 = v2; Reg2 = r2; mem_fwd_val = mv; wb_fwd_val = wv;
                    fwd_sel_a = fa; fwd_sel_b = fb;
                end
            end
            if (!seen) begin
                n_cmp++; n_fail++;
                $display("FAIL mul_timeout: busy still 1 after 100 cycles, required 0");
            end
        end
    endtask

    // Monitor: while busy alu_result must be 0; otherwise pop and compare.
    always @(negedge clk) begin
        if (!mon_en) begin
            run = 0;
        end else if (busy) begin
            run++;
            check("alu_while_busy", alu_result, 32'd0);
        end else begin
            if (sb.size() == 0) begin
                n_cmp++; n_fail++;
                $display("FAIL sb_empty: output presented, no expectation queued");
            end else begin
                me = sb.pop_front();
                check("alu_result", alu_result, me.alu);
                check("st_val", st_val, me.st);
                check("br_addr", br_addr, me.ba);
                check("br_taken", 32'(br_taken), 32'(me.bt));
                check("busy_cycles", 32'(run), 32'(me.busy_len));
            end
            run = 0;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; EXE_CMD = 4'b1111; Val1 = 0; Val2 = 0; Reg2 = 0; PC_in = 0;
        Branch_Type = 0; is_imm = 0; fwd_sel_a = 0; fwd_sel_b = 0;
        mem_fwd_val = 0; wb_fwd_val = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_alu", alu_result, 32'd0);
        @(posedge clk); #1 rst = 1'b0;

        issue(4'd0, 32'd7, 32'hFFFF_FFFE, 0, 0, 2'd0, 1'b1, 2'd0, 2'd0, 0, 0);
        issue(4'd2, 32'd3, 32'd5, 0, 0, 2'd0, 1'b0, 2'd0, 2'd0, 0, 0);
        issue(4'd10, 32'h8000_0000, 32'd4, 0, 0, 2'd0, 1'b1, 2'd0, 2'd0, 0, 0);
        issue(4'd9, 32'h8000_0000, 32'd4, 0, 0, 2'd0, 1'b1, 2'd0, 2'd0, 0, 0);
        issue(4'd11, 32'hFFFF_FFFF, 32'd1, 0, 0, 2'd0, 1'b0, 2'd0, 2'd0, 0, 0);
        issue(4'd0, 32'd99, 32'd1, 0, 0, 2'd0, 1'b1, 2'd1, 2'd0, 32'd10, 0);
        issue(4'd0, 32'd1, 32'd2, 32'd77, 0, 2'd0, 1'b1, 2'd0, 2'd2, 0, 32'h55);
        issue(4'd2, 32'd4, 32'd0, 32'd4, 0, 2'd2, 1'b0, 2'd0, 2'd0, 0, 0);
        issue(4'd2, 32'd4, 32'd3, 32'd5, 32'h40, 2'd2, 1'b0, 2'd0, 2'd0, 0, 0);
        issue(4'd15, 32'd0, 32'd8, 0, 32'h100, 2'd3, 1'b0, 2'd0, 2'd0, 0, 0);
        issue(4'd15, 32'd0, 32'd1, 0, 32'h10, 2'd1, 1'b0, 2'd0, 2'd0, 0, 0);
        issue(4'd12, 32'h12345, 32'h100, 0, 0, 2'd0, 1'b0, 2'd0, 2'd0, 0, 0);
        issue(4'd12, 32'hFFFF_FFFF, 32'd2, 0, 0, 2'd0, 1'b1, 2'd0, 2'd0, 0, 0);

        // Abandon a multiply with reset after ten cycles.
        @(posedge clk); #1;
        mon_en = 1'b0;
        EXE_CMD = 4'b1100; Val1 = 32'd9; Val2 = 32'd9; is_imm = 1'b0;
        fwd_sel_a = 0; fwd_sel_b = 0; Branch_Type = 0;
        repeat (9) @(posedge clk);
        #1 rst = 1'b1; EXE_CMD = 4'b1111;
        @(negedge clk);
        check("busy_before_reset_edge", 32'(busy), 32'd1);
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        check("busy_after_reset", 32'(busy), 32'd0);
        issue(4'd12, 32'd1000, 32'd3000, 0, 0, 2'd0, 1'b0, 2'd0, 2'd0, 0, 0);

        for (int i = 0; i < 300; i++) begin
            issue(4'($urandom_range(0, 15)), $urandom, $urandom, $urandom, $urandom,
                  2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                  2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), $urandom, $urandom);
        end

        @(posedge clk); #1 mon_en = 1'b0;
        check("sb_drained", 32'(sb.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/exe_stage.md
Name: exe_stage

Overview:
- Execute stage of the 5-stage pipeline. Sits directly downstream of the ID/EX pipeline register and consumes its outputs: Val1, Val2, Reg2, PC, EXE_CMD, Branch_Type, is_imm.
- Applies forwarding, computes the ALU result and resolves branches. Produces data for the EX/MEM register and branch redirect for IF.
- Adds a multi-cycle sequential multiplier. While it runs, the block asserts busy, which feeds the Freeze of IF, IF/ID and ID/EX.

Parameters:
- MUL_STEPS, 32, shift-add iterations per multiply (one result bit per cycle)

Ports:
- clk  in  1  pipeline clock
- rst  in  1  reset
- EXE_CMD  in  4  operation code from ID/EX
- Val1  in  32  operand A
- Val2  in  32  operand B, or sign-extended immediate
- Reg2  in  32  rt register value (store data, BNE compare)
- PC_in  in  32  PC+4 of the instruction
- Branch_Type  in  2  00 none, 01 BEZ, 10 BNE, 11 JMP
- is_imm  in  1  operand B is the immediate
- fwd_sel_a  in  2  00 Val1, 01 mem_fwd_val, 10 wb_fwd_val, 11 Val1
- fwd_sel_b  in  2  same encoding, applied to Val2 (when !is_imm) and Reg2
- mem_fwd_val  in  32  EX/MEM ALU result
- wb_fwd_val  in  32  WB write-back value
- alu_result  out  32  result to EX/MEM
- st_val  out  32  forwarded Reg2
- br_taken  out  1  branch redirect
- br_addr  out  32  branch target
- busy  out  1  multiplier occupying EXE; freezes upstream and bubbles EX/MEM

Behaviour:
- Clocking: single clock clk; reset rst is synchronous, active-high.
- Forwarding:
  - A = mux(fwd_sel_a).
  - B = is_imm ? Val2 : mux(fwd_sel_b, Val2).
  - st_val = mux(fwd_sel_b, Reg2).
- EXE_CMD codes (combinational, results wrap mod 2^32):
  - 0000 ADD; 0010 SUB; 0100 AND; 0101 OR; 0110 NOR; 0111 XOR
  - 1000 SLL, 1001 SRL, 1010 SRA: shift amount B[4:0]
  - 1011 SLT: signed, result 1/0
  - 1100 MUL: low 32 bits of A*B
  - 1111 NOP: result 0
  - Any other code: result 0.
- Branches:
  - br_addr = PC_in + (Val2 << 2).
  - BEZ taken iff A == 0.
  - BNE taken iff A != st_val.
  - JMP always taken.
  - br_taken is combinational and 0 when Branch_Type = 00.
- Multiplier FSM, states IDLE, BUSY, DONE:
  - IDLE: if EXE_CMD == MUL, then busy = 1. Latch forwarded A and B into the multiplier (forward sources move while stalled, so latch now). Clear product and count. Go to BUSY.
  - BUSY: busy = 1. One shift-add step per cycle. When count == MUL_STEPS-1, go to DONE.
  - DONE: busy = 0. alu_result = product register. Go to IDLE unconditionally, so a back-to-back MUL restarts from IDLE next cycle.
  - Total for one MUL: busy high 33 cycles, result on cycle 34.
  - While busy, alu_result = 0. The EX/MEM register inserts a bubble when busy.
- Reset:
  - FSM to IDLE, count = 0, product = 0, latched operands = 0, busy = 0.
  - Other outputs are combinational from inputs.
  - Reset mid-multiply abandons the operation; busy drops the cycle after reset is sampled.
- Simultaneous events:
  - A branch is never a MUL, so br_taken and busy are never both 1 for a legal instruction.
  - If EXE_CMD = MUL with Branch_Type != 00, the branch is still resolved combinationally.

Decomposition:
- Package exe_pkg holds:
  - EXE_CMD localparams
  - Branch_Type codes
  - forward-select codes
  - FSM state encoding
- Sub-module mul_seq:
  - Ports: start, a, b, product, done.
  - Radix-2 shift-add core with counter and FSM.
  - exe_stage instantiates it and muxes product into alu_result.

Test Plan:
- ADD, A=7, B=0xFFFFFFFE, fwd 00/00 -> alu_result=5, busy=0 same cycle; SUB 3-5 -> 0xFFFFFFFE.
- SRA B=4 on A=0x80000000 -> 0xF8000000; SRL same -> 0x08000000; SLT -1,1 -> 1.
- fwd_sel_a=01, mem_fwd_val=10, Val1=99, ADD B=1 -> 11; fwd_sel_b=10 with is_imm=1 -> B stays Val2; st_val=wb_fwd_val.
- BNE, A=4, Reg2=4 -> br_taken=0; Reg2=5, PC_in=0x40, Val2=3 -> br_taken=1, br_addr=0x4C; JMP -> 1.
- MUL, A=0x12345, B=0x100 -> busy 33 cycles, alu_result=0x01234500 on cycle 34; forward values changed mid-op do not alter result; back-to-back MUL 0xFFFFFFFF*2 -> 0xFFFFFFFE.
- rst asserted at cycle 10 of a MUL -> busy=0 the following cycle; next MUL gives correct product.
